// File: rtl/dvp_tx_pkg.sv
// Shared definitions for the 16-bit to 8-bit DVP transmitter.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_e;

    // Byte order on the wire: 1 = pixel bits [15:8] leave first.
    localparam bit HI_FIRST = 1'b1;

    // pclk cycles in one line period (bytes plus horizontal blank).
    function automatic int line_len(input int h_active, input int h_blank);
        return 2 * h_active + h_blank;
    endfunction

    // pclk cycles in one complete frame, VSYNC through VFRONT.
    function automatic int frame_len(input int h_active, input int h_blank,
                                     input int vs_lines, input int v_back,
                                     input int v_active, input int v_front);
        return line_len(h_active, h_blank) * (vs_lines + v_back + v_active + v_front);
    endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// Frame sequencer: walks VSYNC/VBACK/ACTIVE/VFRONT in whole line periods and
// flags which cycles carry a byte. All strobes are for the current cycle;
// the top registers them onto the pins.
module dvp_tx_timing
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 10,
    parameter int V_FRONT  = 10
) (
    input  logic   pclk,
    input  logic   rst_n,
    input  logic   start,       // a sof pixel is waiting in the holding register
    output state_e state,
    output logic   byte_en,     // ACTIVE and inside the byte part of the line
    output logic   pix_phase,   // 0 = first byte of a pixel, 1 = second
    output logic   line_start,  // first byte cycle of an active line
    output logic   first_line,  // line counter is at its first line
    output logic   frame_end    // last cycle of VFRONT
);

    localparam int L      = line_len(H_ACTIVE, H_BLANK);
    localparam int VMAX_A = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int VMAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX   = (VMAX_A > VMAX_B) ? VMAX_A : VMAX_B;
    localparam int HW     = (L > 2) ? $clog2(L) : 1;
    localparam int VW     = (VMAX > 2) ? $clog2(VMAX) : 1;

    state_e          state_nx;
    logic [HW-1:0]   hcnt, hcnt_nx;
    logic [VW-1:0]   vcnt, vcnt_nx;
    logic [VW-1:0]   last_line;
    logic            line_end;

    // State and position counters.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state <= IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
            vcnt  <= vcnt_nx;
        end
    end

    // Line count of the current state, used as the vertical terminal value.
    always_comb begin
        case (state)
            VSYNC:   last_line = VW'(VS_LINES - 1);
            VBACK:   last_line = VW'(V_BACK - 1);
            ACTIVE:  last_line = VW'(V_ACTIVE - 1);
            VFRONT:  last_line = VW'(V_FRONT - 1);
            default: last_line = '0;
        endcase
    end

    // Next state and counters; each non-IDLE state lasts whole line periods.
    always_comb begin
        state_nx  = state;
        hcnt_nx   = hcnt;
        vcnt_nx   = vcnt;
        frame_end = 1'b0;
        line_end  = (hcnt == HW'(L - 1));
        if (state == IDLE) begin
            hcnt_nx = '0;
            vcnt_nx = '0;
            if (start) state_nx = VSYNC;
        end else if (!line_end) begin
            hcnt_nx = hcnt + 1'b1;
        end else begin
            hcnt_nx = '0;
            if (vcnt != last_line) begin
                vcnt_nx = vcnt + 1'b1;
            end else begin
                vcnt_nx = '0;
                case (state)
                    VSYNC:   state_nx = VBACK;
                    VBACK:   state_nx = ACTIVE;
                    ACTIVE:  state_nx = VFRONT;
                    default: begin
                        frame_end = 1'b1;
                        state_nx  = start ? VSYNC : IDLE;
                    end
                endcase
            end
        end
    end

    // Byte-slot decode; phase restarts at 0 because hcnt restarts each line.
    always_comb begin
        byte_en    = (state == ACTIVE) && (hcnt < HW'(2 * H_ACTIVE));
        pix_phase  = hcnt[0];
        line_start = (state == ACTIVE) && (hcnt == '0);
        first_line = (vcnt == '0);
    end

endmodule

// File: rtl/dvp_16_8bit_tx.sv
// RGB565 pixel stream to DVP-style 8-bit byte stream with self-generated
// vs/de timing. One-pixel holding register decouples the source handshake
// from the fixed byte schedule; missing pixels become zero bytes.
module dvp_16_8bit_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 10,
    parameter int V_FRONT  = 10
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        pix_valid_i,
    input  logic [15:0] pix_data_i,
    input  logic        pix_sof_i,
    output logic        pix_ready_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [7:0]  pdata_o,
    output logic        underrun_o,
    output logic        sof_err_o,
    output logic        frame_done_o
);

    state_e      state;
    logic        byte_en, pix_phase, line_start, first_line, frame_end;
    logic        hold_full, hold_sof;
    logic [15:0] hold_data;
    logic [7:0]  lo_byte;
    logic        consume, starve, drop, accept, keep, sof_err;
    logic [7:0]  byte_nx;

    dvp_tx_timing #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .VS_LINES (VS_LINES),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT)
    ) u_timing (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .start      (hold_full && hold_sof),
        .state      (state),
        .byte_en    (byte_en),
        .pix_phase  (pix_phase),
        .line_start (line_start),
        .first_line (first_line),
        .frame_end  (frame_end)
    );

    // Handshake, consume/discard decisions and the next byte on the wire.
    always_comb begin
        consume     = byte_en && !pix_phase && hold_full;
        starve      = byte_en && !pix_phase && !hold_full;
        // A non-sof pixel left over after a frame is flushed while idle.
        drop        = (state == IDLE) && hold_full && !hold_sof;
        pix_ready_o = !hold_full || consume || drop;
        accept      = pix_valid_i && pix_ready_o;
        // While idle only a sof pixel is worth keeping; others are swallowed.
        keep        = accept && ((state != IDLE) || pix_sof_i);
        sof_err     = consume && hold_sof && !(line_start && first_line);
        byte_nx     = 8'h00;
        if (byte_en) begin
            if (pix_phase) byte_nx = lo_byte;
            else if (consume) byte_nx = HI_FIRST ? hold_data[15:8] : hold_data[7:0];
        end
    end

    // Holding register and the saved second byte of the pixel in flight.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_sof  <= 1'b0;
            hold_data <= 16'h0000;
            lo_byte   <= 8'h00;
        end else begin
            if (keep) begin
                hold_full <= 1'b1;
                hold_sof  <= pix_sof_i;
                hold_data <= pix_data_i;
            end else if (consume || drop) begin
                hold_full <= 1'b0;
                hold_sof  <= 1'b0;
            end
            if (consume) lo_byte <= HI_FIRST ? hold_data[7:0] : hold_data[15:8];
            else if (starve) lo_byte <= 8'h00;
        end
    end

    // Registered pins, one cycle behind the timing decision.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vs_o         <= 1'b0;
            de_o         <= 1'b0;
            pdata_o      <= 8'h00;
            underrun_o   <= 1'b0;
            sof_err_o    <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            vs_o         <= (state == VSYNC);
            de_o         <= byte_en;
            pdata_o      <= byte_nx;
            underrun_o   <= starve;
            sof_err_o    <= sof_err;
            frame_done_o <= frame_end;
        end
    end

endmodule

// File: tb/tb_dvp_16_8bit_tx.sv
// Directed bench for dvp_16_8bit_tx with a tiny frame (L = 12 pclk).
// Each capture records 80 cycles of outputs; expected waveforms are rebuilt
// from hand-derived frame positions relative to the vs_o rising sample.
module tb_dvp_16_8bit_tx;

    localparam int N = 80;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic [15:0] pix_data_i = 16'h0000;
    logic        pix_sof_i = 1'b0;
    logic        pix_ready_o, vs_o, de_o, underrun_o, sof_err_o, frame_done_o;
    logic [7:0]  pdata_o;

    int tests = 0;
    int fails = 0;

    // captured samples: {vs, de, underrun, sof_err, frame_done, pdata}
    logic [12:0] s_vec [N];
    logic        s_rdy [N];
    int          hs;

    logic [15:0] src_data [16];
    logic        src_sof  [16];
    int          src_n;

    logic [15:0] exp_pix [8];
    logic [7:0]  exp_miss;
    int          exp_err;

    dvp_16_8bit_tx #(
        .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(4),
        .VS_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .pix_valid_i  (pix_valid_i),
        .pix_data_i   (pix_data_i),
        .pix_sof_i    (pix_sof_i),
        .pix_ready_o  (pix_ready_o),
        .vs_o         (vs_o),
        .de_o         (de_o),
        .pdata_o      (pdata_o),
        .underrun_o   (underrun_o),
        .sof_err_o    (sof_err_o),
        .frame_done_o (frame_done_o)
    );

    always #5 pclk = ~pclk;

    // Expected output vector k samples after vs_o first reads high.
    // vs: k 0..11; line 0 bytes k 24..31; line 1 bytes k 36..43; done k 59.
    function automatic logic [12:0] exp_vec(input int k);
        int bp;
        logic [15:0] px;
        logic vs, de, un, se, fd;
        logic [7:0] pd;
        bp = -1;
        if (k >= 24 && k < 32) bp = k - 24;
        else if (k >= 36 && k < 44) bp = k - 36 + 8;
        vs = (k >= 0 && k < 12);
        de = (bp >= 0);
        fd = (k == 59);
        pd = 8'h00; un = 1'b0; se = 1'b0;
        if (de) begin
            px = exp_pix[bp / 2];
            pd = (bp % 2 == 0) ? px[15:8] : px[7:0];
            if (bp % 2 == 0) begin
                un = exp_miss[bp / 2];
                se = ((bp / 2) == exp_err);
            end
        end
        return {vs, de, un, se, fd, pd};
    endfunction

    // Load src with n pixels base+i; sof on pixels whose bit is set in mask.
    task automatic set_src(input int n, input logic [15:0] base, input logic [15:0] mask);
        src_n = n;
        for (int i = 0; i < 16; i++) begin
            src_data[i] = base + 16'(i);
            src_sof[i]  = mask[i];
        end
    endtask

    // Drive the source queue and record N cycles; optional 1-cycle reset.
    task automatic capture(input int rst_at);
        int idx;
        bit off;
        idx = 0; off = 1'b0; hs = 0;
        pix_valid_i = (src_n > 0);
        pix_data_i  = src_data[0];
        pix_sof_i   = src_sof[0];
        for (int t = 0; t < N; t++) begin
            @(negedge pclk);
            s_vec[t] = {vs_o, de_o, underrun_o, sof_err_o, frame_done_o, pdata_o};
            s_rdy[t] = pix_ready_o;
            if (pix_valid_i && pix_ready_o) begin
                idx++;
                hs++;
            end
            @(posedge pclk);
            #1;
            if (t + 1 == rst_at) begin
                rst_n = 1'b0;
                off   = 1'b1;
            end else begin
                rst_n = 1'b1;
            end
            pix_valid_i = !off && (idx < src_n);
            if (idx < src_n) begin
                pix_data_i = src_data[idx];
                pix_sof_i  = src_sof[idx];
            end else begin
                pix_data_i = 16'h0000;
                pix_sof_i  = 1'b0;
            end
        end
        pix_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge pclk);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            tests++;
            if ({vs_o, de_o, underrun_o, sof_err_o, frame_done_o, pdata_o} !== 13'h0) begin
                fails++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=0000", i,
                         {vs_o, de_o, underrun_o, sof_err_o, frame_done_o, pdata_o});
            end
        end
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        pix_valid_i = 1'b0;
        pix_sof_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            tests++;
            if ({pix_ready_o, vs_o, de_o} !== 3'b100) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got rdy/vs/de=%b want=100", i,
                         {pix_ready_o, vs_o, de_o});
            end
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic test_stream();
        set_src(8, 16'hA001, 16'h0001);
        for (int i = 0; i < 8; i++) exp_pix[i] = 16'hA001 + 16'(i);
        exp_miss = 8'h00; exp_err = -1;
        capture(-1);
        for (int t = 0; t < N; t++) begin
            tests++;
            if (s_vec[t] !== exp_vec(t - 3)) begin
                fails++;
                $display("FAIL stream t=%0d got=%h want=%h", t, s_vec[t], exp_vec(t - 3));
            end
        end
        tests++;
        if (hs !== 8) begin
            fails++;
            $display("FAIL stream_handshakes got=%0d want=8", hs);
        end
    endtask

    task automatic test_garbage();
        src_n = 4;
        src_data[0] = 16'h0BAD; src_data[1] = 16'h0BAE; src_data[2] = 16'h0BAF;
        src_data[3] = 16'h1234;
        src_sof[0] = 1'b0; src_sof[1] = 1'b0; src_sof[2] = 1'b0; src_sof[3] = 1'b1;
        exp_pix[0] = 16'h1234;
        for (int i = 1; i < 8; i++) exp_pix[i] = 16'h0000;
        exp_miss = 8'hFE; exp_err = -1;
        capture(-1);
        for (int t = 0; t < 4; t++) begin
            tests++;
            if (s_rdy[t] !== 1'b1) begin
                fails++;
                $display("FAIL garbage_ready t=%0d got=%b want=1", t, s_rdy[t]);
            end
        end
        for (int t = 0; t < N; t++) begin
            tests++;
            if (s_vec[t] !== exp_vec(t - 6)) begin
                fails++;
                $display("FAIL garbage t=%0d got=%h want=%h", t, s_vec[t], exp_vec(t - 6));
            end
        end
    endtask

    task automatic test_starved();
        int un_cnt;
        set_src(1, 16'hBEEF, 16'h0001);
        exp_pix[0] = 16'hBEEF;
        for (int i = 1; i < 8; i++) exp_pix[i] = 16'h0000;
        exp_miss = 8'hFE; exp_err = -1;
        capture(-1);
        un_cnt = 0;
        for (int t = 0; t < N; t++) begin
            if (s_vec[t][10]) un_cnt++;
            tests++;
            if (s_vec[t] !== exp_vec(t - 3)) begin
                fails++;
                $display("FAIL starved t=%0d got=%h want=%h", t, s_vec[t], exp_vec(t - 3));
            end
        end
        tests++;
        if (un_cnt !== 7) begin
            fails++;
            $display("FAIL starved_underruns got=%0d want=7", un_cnt);
        end
    endtask

    task automatic test_back_pressure();
        logic want;
        set_src(8, 16'hB001, 16'h0001);
        capture(-1);
        // ready samples (k = t-3) fall on consume cycles 23,25,27,29,35,37,39
        for (int t = 0; t <= 42; t++) begin
            want = (t == 0) ||
                   ((t - 3) inside {23, 25, 27, 29, 35, 37, 39});
            tests++;
            if (s_rdy[t] !== want) begin
                fails++;
                $display("FAIL backpressure_ready t=%0d got=%b want=%b", t, s_rdy[t], want);
            end
        end
        tests++;
        if (hs !== 8) begin
            fails++;
            $display("FAIL backpressure_handshakes got=%0d want=8", hs);
        end
    endtask

    task automatic test_mid_sof();
        set_src(8, 16'hC001, 16'h0011);
        for (int i = 0; i < 8; i++) exp_pix[i] = 16'hC001 + 16'(i);
        exp_miss = 8'h00; exp_err = 4;
        capture(-1);
        for (int t = 0; t < N; t++) begin
            tests++;
            if (s_vec[t] !== exp_vec(t - 3)) begin
                fails++;
                $display("FAIL mid_sof t=%0d got=%h want=%h", t, s_vec[t], exp_vec(t - 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] want;
        set_src(8, 16'hD001, 16'h0001);
        for (int i = 0; i < 8; i++) exp_pix[i] = 16'hD001 + 16'(i);
        exp_miss = 8'h00; exp_err = -1;
        // reset during line 1 bytes (k = 38 -> t = 41)
        capture(41);
        for (int t = 0; t < N; t++) begin
            want = (t <= 41) ? exp_vec(t - 3) : 13'h0000;
            tests++;
            if (s_vec[t] !== want) begin
                fails++;
                $display("FAIL reset_mid t=%0d got=%h want=%h", t, s_vec[t], want);
            end
        end
        // a fresh sof restarts with a full VSYNC
        set_src(1, 16'h5A5A, 16'h0001);
        exp_pix[0] = 16'h5A5A;
        for (int i = 1; i < 8; i++) exp_pix[i] = 16'h0000;
        exp_miss = 8'hFE;
        capture(-1);
        for (int t = 0; t < N; t++) begin
            tests++;
            if (s_vec[t] !== exp_vec(t - 3)) begin
                fails++;
                $display("FAIL restart t=%0d got=%h want=%h", t, s_vec[t], exp_vec(t - 3));
            end
        end
    endtask

    initial begin
        pix_valid_i = 1'b1;
        pix_sof_i   = 1'b1;
        pix_data_i  = 16'hFFFF;
        test_reset();
        test_stream();
        test_garbage();
        test_starved();
        test_back_pressure();
        test_mid_sof();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
